// File: rtl/dds_upd_if.sv
// Tuning-update handshake bundle between the SPI/MIDI decoder and dds_bank.
//   valid       : update request from the decoder
//   ready       : bank can accept an update this cycle
//   voice       : target voice index (may exceed the bank size; the bank flags it)
//   delta       : new tuning word
//   phase_reset : also zero the voice phase (note-on retrigger)
interface dds_upd_if #(
    parameter int ACC_WIDTH = 32
) ();
    logic                 valid;
    logic                 ready;
    logic [7:0]           voice;
    logic [ACC_WIDTH-1:0] delta;
    logic                 phase_reset;

    modport master (output valid, voice, delta, phase_reset, input ready);
    modport slave  (input valid, voice, delta, phase_reset, output ready);
endinterface

// File: rtl/dds_bank.sv
// Multi-voice phase-accumulator bank.
// Once per sample tick every voice is scanned: phase[v] += delta[v], and the
// top OUT_WIDTH phase bits are emitted together with the voice index.
// Tuning updates are queued in a small FIFO and applied only while IDLE, so a
// frame always sees one consistent set of tuning words.
// Ports:
//   i_clk, i_reset       : clock, asynchronous active-high reset
//   i_sample_tick        : one-cycle pulse that starts a frame
//   upd (slave)          : tuning-update handshake (see dds_upd_if)
//   o_phase              : top phase bits of the voice just accumulated
//   o_voice_index        : voice that o_phase belongs to
//   o_valid              : o_phase/o_voice_index updated this cycle
//   o_frame_done         : accompanies the last voice's o_valid
//   o_overrun            : tick arrived while a frame was in progress
//   o_upd_err            : a popped update targeted a nonexistent voice
module dds_bank #(
    parameter int NUM_VOICES = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int OUT_WIDTH  = 10,
    parameter int UPD_DEPTH  = 4,
    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_sample_tick,
    dds_upd_if.slave             upd,
    output logic [OUT_WIDTH-1:0] o_phase,
    output logic [VW-1:0]        o_voice_index,
    output logic                 o_valid,
    output logic                 o_frame_done,
    output logic                 o_overrun,
    output logic                 o_upd_err
);
    localparam int            AW     = $clog2(UPD_DEPTH);
    localparam logic [VW-1:0] LAST_V = VW'(NUM_VOICES - 1);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_IDLE  = 2'd1,
        S_READ  = 2'd2,
        S_ACCUM = 2'd3
    } state_t;

    state_t        state_r, state_s;
    // Shared index: init sweep counter in INIT, current voice in READ/ACCUM.
    logic [VW-1:0] vidx_r, vidx_s;

    logic [ACC_WIDTH-1:0] phase_mem_r [NUM_VOICES];
    logic [ACC_WIDTH-1:0] delta_mem_r [NUM_VOICES];
    logic [ACC_WIDTH-1:0] rd_phase_r, rd_delta_r;
    logic [ACC_WIDTH-1:0] sum_s;

    logic                 wr_phase_en_s, wr_delta_en_s;
    logic [VW-1:0]        wr_addr_s;
    logic [ACC_WIDTH-1:0] wr_phase_s, wr_delta_s;

    // Update FIFO: pointers carry one extra wrap bit to tell full from empty.
    logic [7:0]           fifo_voice_r [UPD_DEPTH];
    logic [ACC_WIDTH-1:0] fifo_delta_r [UPD_DEPTH];
    logic                 fifo_prst_r  [UPD_DEPTH];
    logic [AW:0]          wr_ptr_r, rd_ptr_r, count_s;
    logic                 full_s, empty_s, push_s, pop_s, head_ok_s;
    logic [7:0]           head_voice_s;

    assign count_s      = wr_ptr_r - rd_ptr_r;
    assign full_s       = (count_s == (AW+1)'(UPD_DEPTH));
    assign empty_s      = (count_s == (AW+1)'(1'b0));
    assign upd.ready    = !full_s && (state_r != S_INIT);
    assign push_s       = upd.valid && upd.ready;
    assign head_voice_s = fifo_voice_r[rd_ptr_r[AW-1:0]];
    assign head_ok_s    = ({1'b0, head_voice_s} < 9'(NUM_VOICES));
    assign sum_s        = rd_phase_r + rd_delta_r;

    // FSM state and voice/init index register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_r <= S_INIT;
            vidx_r  <= VW'(1'b0);
        end else begin
            state_r <= state_s;
            vidx_r  <= vidx_s;
        end
    end

    // Next-state logic plus the single write port shared by INIT, pops and ACCUM.
    always_comb begin
        state_s       = state_r;
        vidx_s        = vidx_r;
        pop_s         = 1'b0;
        wr_phase_en_s = 1'b0;
        wr_delta_en_s = 1'b0;
        wr_addr_s     = vidx_r;
        wr_phase_s    = {ACC_WIDTH{1'b0}};
        wr_delta_s    = {ACC_WIDTH{1'b0}};
        case (state_r)
            S_INIT: begin
                wr_phase_en_s = 1'b1;
                wr_delta_en_s = 1'b1;
                if (vidx_r == LAST_V) begin
                    state_s = S_IDLE;
                    vidx_s  = VW'(1'b0);
                end else begin
                    vidx_s  = vidx_r + VW'(1'b1);
                end
            end
            S_IDLE: begin
                // A tick wins over a pending update so frames start on time.
                if (i_sample_tick) begin
                    state_s = S_READ;
                    vidx_s  = VW'(1'b0);
                end else if (!empty_s) begin
                    pop_s = 1'b1;
                    if (head_ok_s) begin
                        wr_addr_s     = head_voice_s[VW-1:0];
                        wr_delta_en_s = 1'b1;
                        wr_delta_s    = fifo_delta_r[rd_ptr_r[AW-1:0]];
                        wr_phase_en_s = fifo_prst_r[rd_ptr_r[AW-1:0]];
                    end else begin
                        wr_delta_en_s = 1'b0;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_READ: begin
                state_s = S_ACCUM;
            end
            S_ACCUM: begin
                wr_phase_en_s = 1'b1;
                wr_phase_s    = sum_s;
                if (vidx_r == LAST_V) begin
                    state_s = S_IDLE;
                    vidx_s  = VW'(1'b0);
                end else begin
                    state_s = S_READ;
                    vidx_s  = vidx_r + VW'(1'b1);
                end
            end
            default: begin
                state_s = S_INIT;
                vidx_s  = VW'(1'b0);
            end
        endcase
    end

    // Voice storage: synchronous arrays, cleared by the INIT sweep rather than reset.
    always_ff @(posedge i_clk) begin
        if (wr_phase_en_s) phase_mem_r[wr_addr_s] <= wr_phase_s;
        if (wr_delta_en_s) delta_mem_r[wr_addr_s] <= wr_delta_s;
        if (state_r == S_READ) begin
            rd_phase_r <= phase_mem_r[vidx_r];
            rd_delta_r <= delta_mem_r[vidx_r];
        end
    end

    // FIFO entry storage; only the pointers need reset.
    always_ff @(posedge i_clk) begin
        if (push_s) begin
            fifo_voice_r[wr_ptr_r[AW-1:0]] <= upd.voice;
            fifo_delta_r[wr_ptr_r[AW-1:0]] <= upd.delta;
            fifo_prst_r[wr_ptr_r[AW-1:0]]  <= upd.phase_reset;
        end
    end

    // FIFO pointers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_r <= (AW+1)'(1'b0);
            rd_ptr_r <= (AW+1)'(1'b0);
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + (AW+1)'(1'b1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + (AW+1)'(1'b1);
        end
    end

    // Registered outputs; o_phase/o_voice_index hold between valid pulses.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_phase       <= {OUT_WIDTH{1'b0}};
            o_voice_index <= VW'(1'b0);
            o_valid       <= 1'b0;
            o_frame_done  <= 1'b0;
            o_overrun     <= 1'b0;
            o_upd_err     <= 1'b0;
        end else begin
            o_valid      <= (state_r == S_ACCUM);
            o_frame_done <= (state_r == S_ACCUM) && (vidx_r == LAST_V);
            o_overrun    <= i_sample_tick && ((state_r == S_READ) || (state_r == S_ACCUM));
            o_upd_err    <= pop_s && !head_ok_s;
            if (state_r == S_ACCUM) begin
                o_phase       <= sum_s[ACC_WIDTH-1 -: OUT_WIDTH];
                o_voice_index <= vidx_r;
            end
        end
    end
endmodule

// File: tb/tb_dds_bank.sv
// Self-checking bench for dds_bank: a frame-level reference model (whole frame
// computed at the accepted tick, outputs scheduled by cycle) plus literal checks.
module tb_dds_bank;
    localparam int N   = 16;
    localparam int ACC = 32;
    localparam int OW  = 10;
    localparam int D   = 4;
    localparam int VW  = 4;

    logic clk = 1'b0;
    logic i_reset = 1'b0;
    logic i_sample_tick = 1'b0;
    logic [OW-1:0] o_phase;
    logic [VW-1:0] o_voice_index;
    logic o_valid, o_frame_done, o_overrun, o_upd_err;

    dds_upd_if #(.ACC_WIDTH(ACC)) upd_if ();

    dds_bank #(.NUM_VOICES(N), .ACC_WIDTH(ACC), .OUT_WIDTH(OW), .UPD_DEPTH(D)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_sample_tick(i_sample_tick), .upd(upd_if),
        .o_phase(o_phase), .o_voice_index(o_voice_index), .o_valid(o_valid),
        .o_frame_done(o_frame_done), .o_overrun(o_overrun), .o_upd_err(o_upd_err)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; int v; logic [OW-1:0] ph; bit done; } exp_t;
    typedef struct { logic [7:0] voice; logic [ACC-1:0] delta; bit prst; } ent_t;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // reference model state
    logic [ACC-1:0] mphase [N];
    logic [ACC-1:0] mdelta [N];
    ent_t mq[$];
    exp_t expq[$];
    int init_left, frame_t, exp_ovr_cyc, exp_err_cyc;
    logic [OW-1:0] held_ph;
    int held_v;

    // observation counters for literal checks
    int fval_cnt, done_at, first_valid_cyc, tick_cyc, ovr_cnt, err_cnt, acc_cnt;
    logic [OW-1:0] cap_phase [N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < N; v++) begin
            mphase[v] = '0;
            mdelta[v] = '0;
        end
        mq.delete();
        expq.delete();
        init_left = N;
        frame_t = -1000;
        exp_ovr_cyc = -1;
        exp_err_cyc = -1;
        held_ph = '0;
        held_v = 0;
    endtask

    // Reference model: advances one clock cycle using the inputs seen at this edge.
    always @(posedge clk) begin
        bit busy, accept;
        ent_t ent;
        if (i_reset) begin
            model_reset();
        end else if (init_left > 0) begin
            init_left--;
        end else begin
            busy = (cyc >= frame_t + 1) && (cyc <= frame_t + 2 * N);
            accept = upd_if.valid && (mq.size() < D);
            if (busy) begin
                if (i_sample_tick) exp_ovr_cyc = cyc + 1;
            end else if (i_sample_tick) begin
                frame_t = cyc;
                for (int v = 0; v < N; v++) begin
                    mphase[v] = mphase[v] + mdelta[v];
                    expq.push_back('{cyc + 3 + 2 * v, v, mphase[v][ACC-1 -: OW], (v == N - 1)});
                end
            end else if (mq.size() > 0) begin
                ent = mq.pop_front();
                if (int'(ent.voice) < N) begin
                    mdelta[ent.voice] = ent.delta;
                    if (ent.prst) mphase[ent.voice] = '0;
                end else begin
                    exp_err_cyc = cyc + 1;
                end
            end
            if (accept) mq.push_back('{upd_if.voice, upd_if.delta, upd_if.phase_reset});
        end
        cyc++;
    end

    // Compare process: checks every output on every cycle at the falling edge.
    always @(negedge clk) begin
        exp_t e;
        bit ev, ed, er;
        ev = 1'b0;
        ed = 1'b0;
        if (!i_reset && expq.size() > 0 && expq[0].cyc == cyc) begin
            e = expq.pop_front();
            ev = 1'b1;
            ed = e.done;
            held_ph = e.ph;
            held_v = e.v;
        end
        er = !i_reset && (init_left == 0) && (mq.size() < D);
        chk("o_valid", 64'(o_valid), 64'(ev));
        chk("o_frame_done", 64'(o_frame_done), 64'(ed));
        chk("o_phase", 64'(o_phase), 64'(held_ph));
        chk("o_voice_index", 64'(o_voice_index), 64'(held_v));
        chk("o_overrun", 64'(o_overrun), 64'(!i_reset && cyc == exp_ovr_cyc));
        chk("o_upd_err", 64'(o_upd_err), 64'(!i_reset && cyc == exp_err_cyc));
        chk("o_upd_ready", 64'(upd_if.ready), 64'(er));
        if (o_valid) begin
            fval_cnt++;
            cap_phase[o_voice_index] = o_phase;
            if (o_frame_done) done_at = fval_cnt;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        if (o_overrun) ovr_cnt++;
        if (o_upd_err) err_cnt++;
    end

    task automatic clear_obs();
        fval_cnt = 0;
        done_at = 0;
        first_valid_cyc = -1;
        for (int v = 0; v < N; v++) cap_phase[v] = '0;
    endtask

    task automatic pulse_tick();
        @(negedge clk); #1;
        i_sample_tick = 1'b1;
        tick_cyc = cyc;
        @(negedge clk); #1;
        i_sample_tick = 1'b0;
    endtask

    task automatic frame();
        clear_obs();
        pulse_tick();
        repeat (2 * N + 4) @(negedge clk);
        #2;
    endtask

    task automatic push(input logic [7:0] v, input logic [ACC-1:0] d, input bit p);
        @(negedge clk); #1;
        upd_if.valid = 1'b1;
        upd_if.voice = v;
        upd_if.delta = d;
        upd_if.phase_reset = p;
        @(negedge clk); #1;
        upd_if.valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic reset_and_init_check();
        repeat (2) @(negedge clk);
        #1;
        i_reset = 1'b0;
        repeat (N - 1) @(negedge clk);
        #2;
        chk("init_ready_low", 64'(upd_if.ready), 64'(0));
        @(negedge clk);
        #2;
        chk("init_ready_high", 64'(upd_if.ready), 64'(1));
    endtask

    initial begin
        upd_if.valid = 1'b0;
        upd_if.voice = 8'd0;
        upd_if.delta = '0;
        upd_if.phase_reset = 1'b0;
        model_reset();
        clear_obs();
        ovr_cnt = 0;
        err_cnt = 0;
        i_reset = 1'b1;
        reset_and_init_check();

        // first frame: all zero, 16 pulses, latency 3
        frame();
        chk("frame0_count", 64'(fval_cnt), 64'(16));
        chk("frame0_done_pos", 64'(done_at), 64'(16));
        chk("tick_latency", 64'(first_valid_cyc - tick_cyc), 64'(3));
        chk("frame0_v15", 64'(cap_phase[15]), 64'(0));

        // voice 3 steps by one output LSB per frame
        push(8'd3, 32'h0040_0000, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            frame();
            chk("v3_step", 64'(cap_phase[3]), 64'(k));
            chk("v7_still0", 64'(cap_phase[7]), 64'(0));
        end

        // voice 5 wraps modulo 2^32
        push(8'd5, 32'hFFC0_0000, 1'b0);
        frame();
        chk("v5_first", 64'(cap_phase[5]), 64'h3FF);
        frame();
        chk("v5_wrap", 64'(cap_phase[5]), 64'h3FE);

        // voice 2 retrigger
        push(8'd2, 32'h0100_0000, 1'b0);
        frame();
        chk("v2_nonzero", 64'(cap_phase[2]), 64'(4));
        push(8'd2, 32'h0000_0000, 1'b1);
        frame();
        chk("v2_retrig", 64'(cap_phase[2]), 64'(0));
        chk("v5_unaffected", 64'(cap_phase[5]), 64'h3FC);

        // hold valid through a frame: FIFO fills to 4, one bad voice
        err_cnt = 0;
        acc_cnt = 0;
        clear_obs();
        pulse_tick();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            upd_if.valid = 1'b1;
            upd_if.voice = (i == 0) ? 8'd200 : 8'(6 + i);
            upd_if.delta = 32'h0080_0000;
            upd_if.phase_reset = 1'b0;
            if (upd_if.ready) acc_cnt++;
        end
        @(negedge clk); #1;
        upd_if.valid = 1'b0;
        chk("fifo_accepts", 64'(acc_cnt), 64'(4));
        chk("ready_full", 64'(upd_if.ready), 64'(0));
        repeat (2 * N + 4) @(negedge clk);
        #2;
        chk("held_frame_v7_old", 64'(cap_phase[7]), 64'(0));
        chk("upd_err_once", 64'(err_cnt), 64'(1));
        chk("drained_ready", 64'(upd_if.ready), 64'(1));

        // tick mid-frame: one overrun, frame still completes
        ovr_cnt = 0;
        clear_obs();
        pulse_tick();
        repeat (5) @(negedge clk);
        pulse_tick();
        repeat (2 * N + 4) @(negedge clk);
        #2;
        chk("overrun_once", 64'(ovr_cnt), 64'(1));
        chk("overrun_frame_count", 64'(fval_cnt), 64'(16));

        // asynchronous reset mid-frame
        pulse_tick();
        repeat (12) @(posedge clk);
        #2;
        i_reset = 1'b1;
        model_reset();
        #1;
        chk("async_rst_valid", 64'(o_valid), 64'(0));
        chk("async_rst_phase", 64'(o_phase), 64'(0));
        chk("async_rst_index", 64'(o_voice_index), 64'(0));
        reset_and_init_check();
        frame();
        chk("post_rst_v3", 64'(cap_phase[3]), 64'(0));
        chk("post_rst_done_pos", 64'(done_at), 64'(16));

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk); #1;
            i_sample_tick = ($urandom_range(0, 24) == 0);
            upd_if.valid = ($urandom_range(0, 2) == 0);
            upd_if.voice = ($urandom_range(0, 40) == 0) ? 8'd200 : 8'($urandom_range(0, 17));
            upd_if.delta = $urandom;
            upd_if.phase_reset = ($urandom_range(0, 3) == 0);
        end
        @(negedge clk); #1;
        i_sample_tick = 1'b0;
        upd_if.valid = 1'b0;
        repeat (2 * N + 10) @(negedge clk);
        #2;
        chk("final_queue_empty", 64'(expq.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
